// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares one execute ALU between two requesters.
// Ops are registered onto the ALU inputs and returned, tagged with the requester ID.
module alu_share_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_aluop,
  input  logic [6:0]       req0_funct7,
  input  logic [2:0]       req0_funct3,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_aluop,
  input  logic [6:0]       req1_funct7,
  input  logic [2:0]       req1_funct3,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [1:0]       alu_aluop,
  output logic [6:0]       alu_funct7,
  output logic [2:0]       alu_funct3,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e state_q;
  logic   last_grant_q;
  logic   grant1;

  // Requester 1 wins when alone, or on a conflict when requester 0 was served last.
  always_comb begin
    grant1     = req1_valid & (~req0_valid | ~last_grant_q);
    req0_ready = (state_q == StIdle) & req0_valid & ~grant1;
    req1_ready = (state_q == StIdle) & grant1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      alu_aluop    <= '0;
      alu_funct7   <= '0;
      alu_funct3   <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_data     <= '0;
      rsp_zero     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req0_ready || req1_ready) begin
            alu_aluop    <= grant1 ? req1_aluop  : req0_aluop;
            alu_funct7   <= grant1 ? req1_funct7 : req0_funct7;
            alu_funct3   <= grant1 ? req1_funct3 : req0_funct3;
            alu_a        <= grant1 ? req1_a      : req0_a;
            alu_b        <= grant1 ? req1_b      : req0_b;
            rsp_id       <= grant1;
            last_grant_q <= grant1;
            state_q      <= StExec;
          end
        end
        StExec: begin
          rsp_data  <= alu_result;
          rsp_zero  <= alu_zero;
          rsp_valid <= 1'b1;
          state_q   <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed plus randomized checks of alu_share_arbiter against a transaction-level model.
module tb_alu_share_arbiter;

  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_ready, req1_ready;
  logic [1:0]       alu_aluop;
  logic [6:0]       alu_funct7;
  logic [2:0]       alu_funct3;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result, rsp_data;
  logic             alu_zero, rsp_valid, rsp_ready, rsp_id, rsp_zero;

  logic             v     [2];
  logic [1:0]       op    [2];
  logic [6:0]       f7    [2];
  logic [2:0]       f3    [2];
  logic [WIDTH-1:0] opa   [2];
  logic [WIDTH-1:0] opb   [2];

  int   checks = 0;
  int   errors = 0;
  bit   last_g;
  logic [WIDTH-1:0] la, lb;

  always #5 clk = ~clk;

  // Reference ALU: decoder + ALU behaviour the shared unit is expected to have.
  function automatic logic [WIDTH-1:0] alu_f(input logic [1:0] aop, input logic [6:0] fn7,
                                             input logic [2:0] fn3, input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y);
    if (aop == 2'b00) return x + y;
    if (aop == 2'b01) return x - y;
    if (aop == 2'b11) return '0;
    case (fn3)
      3'b000:  return fn7[5] ? x - y : x + y;
      3'b001:  return x << y[4:0];
      3'b010:  return {31'd0, $signed(x) < $signed(y)};
      3'b011:  return {31'd0, x < y};
      3'b100:  return x ^ y;
      3'b101:  return fn7[5] ? WIDTH'($signed(x) >>> y[4:0]) : x >> y[4:0];
      3'b110:  return x | y;
      default: return x & y;
    endcase
  endfunction

  assign alu_result = alu_f(alu_aluop, alu_funct7, alu_funct3, alu_a, alu_b);
  assign alu_zero   = (alu_result == '0);

  alu_share_arbiter #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (v[0]),
    .req0_ready (req0_ready),
    .req0_aluop (op[0]),
    .req0_funct7(f7[0]),
    .req0_funct3(f3[0]),
    .req0_a     (opa[0]),
    .req0_b     (opb[0]),
    .req1_valid (v[1]),
    .req1_ready (req1_ready),
    .req1_aluop (op[1]),
    .req1_funct7(f7[1]),
    .req1_funct3(f3[1]),
    .req1_a     (opa[1]),
    .req1_b     (opb[1]),
    .alu_aluop  (alu_aluop),
    .alu_funct7 (alu_funct7),
    .alu_funct3 (alu_funct3),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_zero   (rsp_zero)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [1:0] aop, input logic [6:0] fn7,
                         input logic [2:0] fn3, input logic [WIDTH-1:0] x,
                         input logic [WIDTH-1:0] y);
    op[id] = aop; f7[id] = fn7; f3[id] = fn3; opa[id] = x; opb[id] = y;
  endtask

  task automatic rand_req(input int id);
    set_req(id, 2'($urandom_range(0, 2)), ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00,
            3'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom);
  endtask

  task automatic check_zero_state(input string tag);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_alu_a"}, alu_a, 0);
    chk({tag, "_alu_b"}, alu_b, 0);
    chk({tag, "_alu_aluop"}, alu_aluop, 0);
    chk({tag, "_alu_funct7"}, alu_funct7, 0);
    chk({tag, "_alu_funct3"}, alu_funct3, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_zero"}, rsp_zero, 0);
    chk({tag, "_rsp_id"}, rsp_id, 0);
  endtask

  // One full transaction from IDLE; inputs are already driven. stall = cycles of rsp_ready low.
  // renew keeps the granted requester valid with a fresh op once accepted.
  task automatic txn(input string tag, input int stall, input bit renew);
    bit g;
    logic [WIDTH-1:0] eres;
    logic [1:0] eop; logic [6:0] ef7; logic [2:0] ef3; logic [WIDTH-1:0] ea, eb;
    #1;
    g = (v[0] && v[1]) ? ~last_g : (v[0] ? 1'b0 : 1'b1);
    chk({tag, "_ready0"}, req0_ready, (g == 1'b0));
    chk({tag, "_ready1"}, req1_ready, (g == 1'b1));
    eop = op[g]; ef7 = f7[g]; ef3 = f3[g]; ea = opa[g]; eb = opb[g];
    eres = alu_f(eop, ef7, ef3, ea, eb);
    last_g = g;
    tick();
    chk({tag, "_exec_a"}, alu_a, ea);
    chk({tag, "_exec_b"}, alu_b, eb);
    chk({tag, "_exec_aluop"}, alu_aluop, eop);
    chk({tag, "_exec_funct7"}, alu_funct7, ef7);
    chk({tag, "_exec_funct3"}, alu_funct3, ef3);
    chk({tag, "_exec_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_exec_readys"}, {req0_ready, req1_ready}, 0);
    if (renew) rand_req(int'(g));
    else v[g] = 1'b0;
    rsp_ready = (stall == 0);
    tick();
    chk({tag, "_rsp_valid"}, rsp_valid, 1);
    chk({tag, "_rsp_data"}, rsp_data, eres);
    chk({tag, "_rsp_id"}, rsp_id, g);
    chk({tag, "_rsp_zero"}, rsp_zero, (eres == '0));
    for (int k = 0; k < stall; k++) begin
      tick();
      chk({tag, "_bp_valid"}, rsp_valid, 1);
      chk({tag, "_bp_data"}, rsp_data, eres);
      chk({tag, "_bp_id"}, rsp_id, g);
      chk({tag, "_bp_readys"}, {req0_ready, req1_ready}, 0);
      chk({tag, "_bp_alu_a"}, alu_a, ea);
      if (k == stall - 1) rsp_ready = 1'b1;
    end
    tick();
    chk({tag, "_done_rsp_valid"}, rsp_valid, 0);
    rsp_ready = 1'b0;
    la = ea;
    lb = eb;
  endtask

  initial begin
    v[0] = 0; v[1] = 0; rsp_ready = 0; reset = 1;
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0);
    tick(); tick();
    reset = 0;
    last_g = 1'b1; la = '0; lb = '0;
    check_zero_state("reset");
    chk("reset_readys", {req0_ready, req1_ready}, 0);

    // Conflict out of reset: requester 0 first, then requester 1.
    set_req(0, 2'b10, 7'b0100000, 3'b000, 32'd9, 32'd9);
    set_req(1, 2'b10, 7'b0000000, 3'b100, 32'hF0, 32'h0F);
    v[0] = 1; v[1] = 1;
    txn("conflict_r0", 0, 0);
    txn("conflict_r1", 0, 0);

    // Both continuously valid: grants alternate.
    v[0] = 1; v[1] = 1; rand_req(0); rand_req(1);
    for (int i = 0; i < 6; i++) txn("alternate", 0, 1);
    v[0] = 0; v[1] = 0;

    // Single add on requester 0.
    set_req(0, 2'b00, 7'd0, 3'd0, 32'd5, 32'd7);
    v[0] = 1;
    txn("single_add", 0, 0);

    // Passthrough of decode fields with an arithmetic shift.
    set_req(1, 2'b10, 7'b0100000, 3'b101, 32'h8000_0000, 32'd4);
    v[1] = 1;
    txn("sra", 0, 0);

    // Backpressure with both requesters waiting.
    v[0] = 1; v[1] = 1; rand_req(0); rand_req(1);
    txn("backpressure", 4, 1);
    v[0] = 0; v[1] = 0;

    // Idle: nothing moves.
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_readys", {req0_ready, req1_ready}, 0);
      chk("idle_rsp_valid", rsp_valid, 0);
      chk("idle_alu_a", alu_a, la);
      chk("idle_alu_b", alu_b, lb);
    end

    // Reset during EXEC: no response, everything cleared, requester 0 wins next conflict.
    set_req(1, 2'b01, 7'd0, 3'd0, 32'd100, 32'd1);
    v[1] = 1;
    #1;
    chk("rst_mid_accept", req1_ready, 1);
    tick();
    v[1] = 0; reset = 1;
    tick();
    reset = 0;
    last_g = 1'b1; la = '0; lb = '0;
    check_zero_state("rst_mid");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_mid_no_rsp", rsp_valid, 0);
    end
    v[0] = 1; v[1] = 1; rand_req(0); rand_req(1);
    txn("post_reset_conflict", 0, 0);
    v[0] = 0; v[1] = 0;

    // Randomized traffic against the model.
    for (int i = 0; i < 40; i++) begin
      v[0] = ($urandom_range(0, 1) != 0);
      v[1] = ($urandom_range(0, 1) != 0);
      if (!v[0] && !v[1]) v[$urandom_range(0, 1)] = 1'b1;
      rand_req(0); rand_req(1);
      txn("random", $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Round-robin arbiter and sequencer that shares the single execute ALU (ALU control decoder plus ALU) between two requesters, for example the integer pipe and the address-generation path. It accepts one operation at a time over a valid/ready handshake and registers the operands and decode fields onto the shared ALU inputs. It then captures the ALU result and returns it, tagged with the requester ID, over a response handshake.

## Interface
Parameters:
- WIDTH, 32, operand and result width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid / req1_valid  in  1  request from requester 0 / 1.
- req0_ready / req1_ready  out  1  request accepted on this edge when valid & ready.
- req0_aluop / req1_aluop  in  2  ALU op class: 00 add, 01 sub, 10 R-type decode.
- req0_funct7 / req1_funct7  in  7  instruction funct7.
- req0_funct3 / req1_funct3  in  3  instruction funct3.
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands.
- alu_aluop  out  2  registered aluop to the ALU control decoder.
- alu_funct7  out  7  registered funct7 to the decoder.
- alu_funct3  out  3  registered funct3 to the decoder.
- alu_a, alu_b  out  WIDTH  registered ALU operands.
- alu_result  in  WIDTH  combinational ALU result for the current alu_* values.
- alu_zero  in  1  combinational ALU zero flag.
- rsp_valid  out  1  response holding.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester that issued the op.
- rsp_data  out  WIDTH  captured result.
- rsp_zero  out  1  captured zero flag.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE
  - Grant selection: if exactly one reqN_valid is high, grant N. If both are high, grant the requester that is not last_grant.
  - reqN_ready = (state==IDLE) & grant==N. It may depend combinationally on the valid inputs; at most one ready is high per cycle.
  - On acceptance: latch aluop, funct7, funct3, a and b into the alu_* registers, latch rsp_id = N, set last_grant = N, go to EXEC.
  - With no valid request, stay in IDLE.
- EXEC
  - The alu_* registers are stable and drive the ALU for exactly one cycle.
  - On the edge: rsp_data <= alu_result, rsp_zero <= alu_zero, go to RESP.
- RESP
  - rsp_valid = 1. rsp_id, rsp_data and rsp_zero hold stable until the transfer.
  - rsp_valid & rsp_ready → IDLE on the same edge. Otherwise stay in RESP.
- Both ready outputs are 0 in EXEC and RESP; requesters must hold their request.
- alu_* registers keep their last value outside EXEC. They are only loaded on acceptance.
- Reset, including mid-EXEC or mid-RESP:
  - The in-flight operation is discarded with no response.
  - state = IDLE, last_grant = 1, so requester 0 wins the first conflict.
  - All alu_* outputs, rsp_data, rsp_zero and rsp_id = 0; rsp_valid = 0.
- Width: no arithmetic inside the block; fields pass through unmodified at their stated widths.

## Timing
- Edge E0: request accepted (valid & ready).
- Cycle after E0: alu_* outputs show the new op (EXEC).
- Edge E1 (one cycle after E0): result captured.
- Cycle after E1: rsp_valid = 1. Latency from acceptance edge to rsp_valid is 2 cycles.
- Maximum throughput: one op per 3 cycles, when rsp_ready is high in the first RESP cycle. IDLE can accept on the cycle right after the response transfer.
- Outputs are registered except reqN_ready, which is combinational from state, last_grant and the valid inputs.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1…
- Backpressure: rsp_ready low for K cycles extends RESP by K cycles. No request is accepted during that time.

## Test plan
- Single request: req0 add, aluop=00, a=5, b=7. Bench ALU model returns a+b. Expect req0_ready high in the acceptance cycle, then alu_a=5 / alu_b=7 one cycle later, then rsp_valid with rsp_data=12, rsp_id=0, rsp_zero=0 two cycles after acceptance.
- Conflict out of reset: both valid. req0: sub, aluop=10, funct7=0100000, funct3=000, 9-9. req1: xor, funct3=100, 0xF0^0x0F. Expect req0 first (rsp_data=0, rsp_zero=1), then req1 (rsp_data=0xFF, rsp_id=1). Grants alternate over 6 further back-to-back ops.
- Backpressure: hold rsp_ready=0 for 4 cycles in RESP. Expect rsp_valid, rsp_data and rsp_id stable; both readys 0; no alu_* change. Transfer on the first rsp_ready=1 edge.
- Passthrough: req1 sra, aluop=10, funct7=0100000, funct3=101, a=0x80000000, b=4. Expect alu_funct7/funct3/aluop exactly as given in EXEC and rsp_data=0xF8000000.
- Reset mid-op: assert reset during EXEC. Expect rsp_valid never rises, all outputs 0 the next cycle, and the next both-valid conflict grants req0.
- Idle: no valid for 10 cycles. Expect state IDLE, readys low, rsp_valid 0, alu_* unchanged.
